// File: rtl/wb_burst_master.sv
// ---------------------------------------------------------------------------
// wb_burst_master
//
// Converts a simple CPU-side request port into Wishbone cycles for the
// on-chip RAM slave. Single requests become classic cycles (cti 000) with
// byte selects. Line-fill read requests become incrementing bursts
// (cti 010, final beat 111) of BURST_LEN words. Every acknowledged beat is
// returned as a one-cycle registered response. A watchdog aborts any cycle
// whose slave never acknowledges.
//
// Request handshake: a request transfers on a rising edge where
// req_i & req_rdy_o are both 1. req_rdy_o is high only while idle. The
// requester holds req_i and its fields stable until that edge. There is no
// back-pressure on the response side: rsp_valid_o pulses once per beat.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_*               request port (valid/ready, see above)
//   rsp_valid_o         one-cycle pulse per completed beat
//   rsp_dat_o           read data of the beat (holds otherwise)
//   rsp_last_o          final beat of an access (always 1 for singles)
//   rsp_err_o           beat ended by a watchdog abort
//   wb_*                Wishbone master port
//   dbg_state_o         current FSM state, for checkers
// ---------------------------------------------------------------------------
module wb_burst_master #(
    parameter int dat_width = 32,
    parameter int adr_width = 10,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 req_we_i,
    input  logic                 req_burst_i,
    input  logic [adr_width-1:0] req_adr_i,
    input  logic [dat_width-1:0] req_dat_i,
    input  logic [3:0]           req_sel_i,
    output logic                 req_rdy_o,
    output logic                 rsp_valid_o,
    output logic [dat_width-1:0] rsp_dat_o,
    output logic                 rsp_last_o,
    output logic                 rsp_err_o,
    output logic [adr_width-1:0] wb_adr_o,
    output logic [dat_width-1:0] wb_dat_o,
    input  logic [dat_width-1:0] wb_dat_i,
    output logic                 wb_we_o,
    output logic [3:0]           wb_sel_o,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic [2:0]           wb_cti_o,
    input  logic                 wb_ack_i,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        BURST  = 2'd2
    } state_t;

    localparam int             KW      = $clog2(BURST_LEN);
    localparam logic [KW-1:0]  K_LAST  = KW'(BURST_LEN - 1);
    localparam logic [KW-1:0]  K_PEN   = KW'(BURST_LEN - 2);
    // Abort fires on the edge where the no-ack count would reach TIMEOUT,
    // so cyc is held for exactly TIMEOUT cycles without an ack.
    localparam logic [7:0]     WD_LAST = 8'(TIMEOUT - 1);

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    state_t                 state_q, state_d;
    logic [adr_width-1:0]   adr_q, adr_d;
    logic [dat_width-1:0]   dat_q, dat_d;
    logic                   we_q, we_d;
    logic [3:0]             sel_q, sel_d;
    logic                   cyc_q, cyc_d;
    logic [2:0]             cti_q, cti_d;
    logic [KW-1:0]          k_q, k_d;
    logic [7:0]             wd_q, wd_d;
    logic                   rdy_q, rdy_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_last_q, rsp_last_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [dat_width-1:0]   rsp_dat_q, rsp_dat_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= 4'b0000;
            cyc_q       <= 1'b0;
            cti_q       <= CTI_CLASSIC;
            k_q         <= '0;
            wd_q        <= '0;
            rdy_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            cyc_q       <= cyc_d;
            cti_q       <= cti_d;
            k_q         <= k_d;
            wd_q        <= wd_d;
            rdy_q       <= rdy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        we_d        = we_q;
        sel_d       = sel_q;
        cyc_d       = cyc_q;
        cti_d       = cti_q;
        k_d         = k_q;
        wd_d        = wd_q;
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_dat_d   = rsp_dat_q;

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    adr_d = req_adr_i;
                    dat_d = req_dat_i;
                    cyc_d = 1'b1;
                    k_d   = '0;
                    wd_d  = '0;
                    if (req_burst_i && !req_we_i) begin
                        state_d = BURST;
                        we_d    = 1'b0;
                        sel_d   = 4'b1111;
                        cti_d   = CTI_INCR;
                    end else begin
                        state_d = SINGLE;
                        we_d    = req_we_i;
                        sel_d   = req_sel_i;
                        cti_d   = CTI_CLASSIC;
                    end
                end
            end

            SINGLE: begin
                if (wb_ack_i) begin
                    cyc_d       = 1'b0;
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = 1'b1;
                    if (!we_q) begin
                        rsp_dat_d = wb_dat_i;
                    end
                end else if (wd_q == WD_LAST) begin
                    cyc_d       = 1'b0;
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end

            BURST: begin
                if (wb_ack_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = wb_dat_i;
                    adr_d       = adr_q + adr_width'(1);
                    wd_d        = '0;
                    if (k_q == K_LAST) begin
                        cyc_d      = 1'b0;
                        cti_d      = CTI_CLASSIC;
                        state_d    = IDLE;
                        rsp_last_d = 1'b1;
                    end else begin
                        k_d = k_q + KW'(1);
                        // cti is registered, so flag the end one beat early.
                        if (k_q == K_PEN) begin
                            cti_d = CTI_END;
                        end
                    end
                end else if (wd_q == WD_LAST) begin
                    cyc_d       = 1'b0;
                    cti_d       = CTI_CLASSIC;
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase

        rdy_d = (state_d == IDLE);
    end

    assign req_rdy_o   = rdy_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_last_o  = rsp_last_q;
    assign rsp_err_o   = rsp_err_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_we_o     = we_q;
    assign wb_sel_o    = sel_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_cti_o    = cti_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// ---------------------------------------------------------------------------
// tb_wb_burst_master
//
// Directed bench for wb_burst_master with a behavioural RAM slave: ack is
// registered one cycle after stb and stays high across incrementing bursts.
// Inputs change and outputs are sampled on the falling edge. Cycle 1 below
// is the first cycle after the request is accepted.
// ---------------------------------------------------------------------------
module tb_wb_burst_master;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_i, req_we_i, req_burst_i;
    logic [9:0]  req_adr_i;
    logic [31:0] req_dat_i;
    logic [3:0]  req_sel_i;
    logic        req_rdy_o;
    logic        rsp_valid_o, rsp_last_o, rsp_err_o;
    logic [31:0] rsp_dat_o;
    logic [9:0]  wb_adr_o;
    logic [31:0] wb_dat_o, wb_dat_i;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  dbg_state;

    // slave model controls
    logic        slv_ack, ack_force, mute;
    logic        pre_we;
    logic [9:0]  pre_adr;
    logic [31:0] pre_dat;
    logic [31:0] mem [0:1023];

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    wb_burst_master #(
        .dat_width(32), .adr_width(10), .BURST_LEN(4), .TIMEOUT(8)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_i(req_i), .req_we_i(req_we_i), .req_burst_i(req_burst_i),
        .req_adr_i(req_adr_i), .req_dat_i(req_dat_i), .req_sel_i(req_sel_i),
        .req_rdy_o(req_rdy_o),
        .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o),
        .rsp_last_o(rsp_last_o), .rsp_err_o(rsp_err_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- RAM slave model ----------------
    assign wb_dat_i = mem[wb_adr_o];
    assign wb_ack_i = slv_ack | ack_force;

    always @(posedge clk) begin
        if (pre_we) mem[pre_adr] <= pre_dat;
        if (rst_i) begin
            slv_ack <= 1'b0;
        end else begin
            slv_ack <= wb_cyc_o & wb_stb_o & !mute & (!slv_ack | (wb_cti_o == 3'b010));
            if (slv_ack && wb_cyc_o && wb_stb_o && wb_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (wb_sel_o[b]) mem[wb_adr_o][8*b +: 8] <= wb_dat_o[8*b +: 8];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_adr = a; pre_dat = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Called on a falling edge while idle; returns in cycle 1.
    task automatic issue(input logic we, input logic burst, input logic [9:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        req_i = 1'b1; req_we_i = we; req_burst_i = burst;
        req_adr_i = adr; req_dat_i = dat; req_sel_i = sel;
        @(negedge clk);
        req_i = 1'b0; req_we_i = 1'b0; req_burst_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_sel_o} !== 10'b0) begin
            errors++; $display("FAIL reset_wb_ctl got=%b exp=%b", {wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_sel_o}, 10'b0); end
        checks++; if ({rsp_valid_o, rsp_last_o, rsp_err_o} !== 3'b000) begin
            errors++; $display("FAIL reset_rsp got=%b exp=000", {rsp_valid_o, rsp_last_o, rsp_err_o}); end
        checks++; if (wb_adr_o !== 10'h000) begin
            errors++; $display("FAIL reset_adr got=%h exp=000", wb_adr_o); end
        checks++; if (wb_dat_o !== 32'h0) begin
            errors++; $display("FAIL reset_wb_dat got=%h exp=0", wb_dat_o); end
        checks++; if (rsp_dat_o !== 32'h0) begin
            errors++; $display("FAIL reset_rsp_dat got=%h exp=0", rsp_dat_o); end
        checks++; if (req_rdy_o !== 1'b1) begin
            errors++; $display("FAIL reset_rdy got=%b exp=1", req_rdy_o); end
        checks++; if (dbg_state !== 2'd0) begin
            errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    endtask

    task automatic test_single_write;
        issue(1'b1, 1'b0, 10'h005, 32'h11223344, 4'hf);
        // cycle 1
        checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o} !== 6'b111000) begin
            errors++; $display("FAIL wr_c1_ctl got=%b exp=111000", {wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o}); end
        checks++; if ({wb_adr_o, wb_dat_o, wb_sel_o} !== {10'h005, 32'h11223344, 4'hf}) begin
            errors++; $display("FAIL wr_c1_fields got=%h/%h/%h exp=005/11223344/f", wb_adr_o, wb_dat_o, wb_sel_o); end
        checks++; if (req_rdy_o !== 1'b0) begin
            errors++; $display("FAIL wr_c1_rdy got=%b exp=0", req_rdy_o); end
        @(negedge clk); // cycle 2
        checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_ack_i} !== 7'b1110001) begin
            errors++; $display("FAIL wr_c2_ctl got=%b exp=1110001", {wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_ack_i}); end
        @(negedge clk); // cycle 3
        checks++; if ({wb_cyc_o, rsp_valid_o, rsp_last_o, rsp_err_o, req_rdy_o} !== 5'b01101) begin
            errors++; $display("FAIL wr_c3_rsp got=%b exp=01101", {wb_cyc_o, rsp_valid_o, rsp_last_o, rsp_err_o, req_rdy_o}); end
        checks++; if (rsp_dat_o !== 32'h0) begin
            errors++; $display("FAIL wr_c3_dat_hold got=%h exp=0", rsp_dat_o); end
        @(negedge clk); // cycle 4
        checks++; if (rsp_valid_o !== 1'b0) begin
            errors++; $display("FAIL wr_c4_valid got=%b exp=0", rsp_valid_o); end
    endtask

    task automatic test_single_read;
        issue(1'b0, 1'b0, 10'h005, 32'h0, 4'hf);
        checks++; if ({wb_cyc_o, wb_we_o, wb_cti_o} !== 5'b10000) begin
            errors++; $display("FAIL rd_c1_ctl got=%b exp=10000", {wb_cyc_o, wb_we_o, wb_cti_o}); end
        repeat (2) @(negedge clk); // cycle 3
        checks++; if ({rsp_valid_o, rsp_last_o, rsp_err_o} !== 3'b110) begin
            errors++; $display("FAIL rd_c3_rsp got=%b exp=110", {rsp_valid_o, rsp_last_o, rsp_err_o}); end
        checks++; if (rsp_dat_o !== 32'h11223344) begin
            errors++; $display("FAIL rd_c3_dat got=%h exp=11223344", rsp_dat_o); end
        @(negedge clk);
    endtask

    task automatic test_byte_write;
        issue(1'b1, 1'b0, 10'h005, 32'hAABBCCDD, 4'b0100);
        checks++; if (wb_sel_o !== 4'b0100) begin
            errors++; $display("FAIL bw_sel got=%b exp=0100", wb_sel_o); end
        repeat (2) @(negedge clk);
        checks++; if ({rsp_valid_o, rsp_dat_o} !== {1'b1, 32'h11223344}) begin
            errors++; $display("FAIL bw_rsp_hold got=%b/%h exp=1/11223344", rsp_valid_o, rsp_dat_o); end
        issue(1'b0, 1'b0, 10'h005, 32'h0, 4'hf);
        repeat (2) @(negedge clk);
        checks++; if ({rsp_valid_o, rsp_dat_o} !== {1'b1, 32'h11BB3344}) begin
            errors++; $display("FAIL bw_readback got=%b/%h exp=1/11bb3344", rsp_valid_o, rsp_dat_o); end
        @(negedge clk);
    endtask

    task automatic test_line_fill;
        logic [9:0] e_adr [6] = '{10'h010, 10'h010, 10'h011, 10'h012, 10'h013, 10'h014};
        logic [2:0] e_cti [5] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b111};
        logic [5:0] e_cyc   = 6'b011111; // bit c-1 = cycle c
        logic [5:0] e_valid = 6'b111100;
        logic [5:0] e_last  = 6'b100000;
        logic [31:0] e;
        for (int i = 0; i < 4; i++) preload(10'h010 + 10'(i), 32'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i));
        issue(1'b0, 1'b1, 10'h010, 32'h0, 4'h0);
        checks++; if ({wb_we_o, wb_sel_o} !== 5'b01111) begin
            errors++; $display("FAIL lf_we_sel got=%b exp=01111", {wb_we_o, wb_sel_o}); end
        for (int c = 1; c <= 6; c++) begin
            checks++; if ({wb_cyc_o, wb_stb_o} !== {2{e_cyc[c-1]}}) begin
                errors++; $display("FAIL lf_cyc_c%0d got=%b exp=%b", c, wb_cyc_o, e_cyc[c-1]); end
            checks++; if (wb_adr_o !== e_adr[c-1]) begin
                errors++; $display("FAIL lf_adr_c%0d got=%h exp=%h", c, wb_adr_o, e_adr[c-1]); end
            if (c <= 5) begin
                checks++; if (wb_cti_o !== e_cti[c-1]) begin
                    errors++; $display("FAIL lf_cti_c%0d got=%b exp=%b", c, wb_cti_o, e_cti[c-1]); end
            end
            checks++; if ({rsp_valid_o, rsp_last_o, rsp_err_o} !== {e_valid[c-1], e_last[c-1], 1'b0}) begin
                errors++; $display("FAIL lf_rsp_c%0d got=%b exp=%b", c, {rsp_valid_o, rsp_last_o, rsp_err_o}, {e_valid[c-1], e_last[c-1], 1'b0}); end
            if (e_valid[c-1] && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++; if (rsp_dat_o !== e) begin
                    errors++; $display("FAIL lf_dat_c%0d got=%h exp=%h", c, rsp_dat_o, e); end
            end
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0 || rsp_valid_o !== 1'b0) begin
            errors++; $display("FAIL lf_tail got=%0d/%b exp=0/0", exp_q.size(), rsp_valid_o); end
        exp_q.delete();
    endtask

    task automatic test_wrap;
        logic [9:0] e_adr [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        logic [31:0] e;
        preload(10'h3FE, 32'hA0); preload(10'h3FF, 32'hA1);
        preload(10'h000, 32'hA2); preload(10'h001, 32'hA3);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + 32'(i));
        issue(1'b0, 1'b1, 10'h3FE, 32'h0, 4'h0);
        for (int c = 1; c <= 6; c++) begin
            if (c >= 2 && c <= 5) begin
                checks++; if ($isunknown(wb_adr_o) || wb_adr_o !== e_adr[c-2]) begin
                    errors++; $display("FAIL wrap_adr_c%0d got=%h exp=%h", c, wb_adr_o, e_adr[c-2]); end
            end
            if (c >= 3 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++; if ({rsp_valid_o, rsp_dat_o} !== {1'b1, e}) begin
                    errors++; $display("FAIL wrap_rsp_c%0d got=%b/%h exp=1/%h", c, rsp_valid_o, rsp_dat_o, e); end
            end
            if (c == 6) begin
                checks++; if ({wb_cyc_o, rsp_last_o, wb_adr_o} !== {1'b0, 1'b1, 10'h002}) begin
                    errors++; $display("FAIL wrap_end got=%b/%b/%h exp=0/1/002", wb_cyc_o, rsp_last_o, wb_adr_o); end
            end
            @(negedge clk);
        end
        exp_q.delete();
    endtask

    task automatic test_timeout;
        mute = 1'b1;
        issue(1'b0, 1'b0, 10'h020, 32'h0, 4'hf);
        for (int c = 1; c <= 8; c++) begin
            checks++; if ({wb_cyc_o, rsp_valid_o} !== 2'b10) begin
                errors++; $display("FAIL to_hold_c%0d got=%b exp=10", c, {wb_cyc_o, rsp_valid_o}); end
            @(negedge clk);
        end
        checks++; if ({wb_cyc_o, wb_stb_o, rsp_valid_o, rsp_last_o, rsp_err_o, req_rdy_o} !== 6'b001111) begin
            errors++; $display("FAIL to_abort got=%b exp=001111", {wb_cyc_o, wb_stb_o, rsp_valid_o, rsp_last_o, rsp_err_o, req_rdy_o}); end
        @(negedge clk);
        checks++; if (rsp_valid_o !== 1'b0) begin
            errors++; $display("FAIL to_single_pulse got=%b exp=0", rsp_valid_o); end
        mute = 1'b0;
    endtask

    task automatic test_reset_mid_burst;
        issue(1'b0, 1'b1, 10'h010, 32'h0, 4'h0);
        repeat (2) @(negedge clk); // cycle 3: second beat on the bus
        rst_i = 1'b1;
        @(negedge clk);
        checks++; if ({wb_cyc_o, wb_stb_o, rsp_valid_o} !== 3'b000) begin
            errors++; $display("FAIL rst_mid got=%b exp=000", {wb_cyc_o, wb_stb_o, rsp_valid_o}); end
        rst_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if ({wb_cyc_o, rsp_valid_o} !== 2'b00) begin
                errors++; $display("FAIL rst_quiet_%0d got=%b exp=00", c, {wb_cyc_o, rsp_valid_o}); end
        end
        checks++; if (req_rdy_o !== 1'b1) begin
            errors++; $display("FAIL rst_rdy got=%b exp=1", req_rdy_o); end
    endtask

    task automatic test_spurious_ack;
        ack_force = 1'b1;
        @(negedge clk);
        ack_force = 1'b0;
        checks++; if ({wb_cyc_o, rsp_valid_o} !== 2'b00) begin
            errors++; $display("FAIL spur_ack_0 got=%b exp=00", {wb_cyc_o, rsp_valid_o}); end
        @(negedge clk);
        checks++; if ({rsp_valid_o, req_rdy_o} !== 2'b01) begin
            errors++; $display("FAIL spur_ack_1 got=%b exp=01", {rsp_valid_o, req_rdy_o}); end
    endtask

    task automatic test_back_to_back;
        issue(1'b1, 1'b0, 10'h030, 32'h12345678, 4'hf);
        repeat (2) @(negedge clk); // cycle 3 of the write
        checks++; if ({req_rdy_o, rsp_valid_o} !== 2'b11) begin
            errors++; $display("FAIL b2b_rdy got=%b exp=11", {req_rdy_o, rsp_valid_o}); end
        issue(1'b0, 1'b0, 10'h030, 32'h0, 4'hf);
        checks++; if ({wb_cyc_o, wb_we_o, wb_adr_o} !== {2'b10, 10'h030}) begin
            errors++; $display("FAIL b2b_start got=%b/%b/%h exp=1/0/030", wb_cyc_o, wb_we_o, wb_adr_o); end
        repeat (2) @(negedge clk);
        checks++; if ({rsp_valid_o, rsp_dat_o} !== {1'b1, 32'h12345678}) begin
            errors++; $display("FAIL b2b_read got=%b/%h exp=1/12345678", rsp_valid_o, rsp_dat_o); end
        @(negedge clk);
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        rst_i = 1'b1; req_i = 1'b0; req_we_i = 1'b0; req_burst_i = 1'b0;
        req_adr_i = '0; req_dat_i = '0; req_sel_i = '0;
        ack_force = 1'b0; mute = 1'b0; pre_we = 1'b0; pre_adr = '0; pre_dat = '0;
        test_reset();
        test_single_write();
        test_single_read();
        test_byte_write();
        test_line_fill();
        test_wrap();
        test_timeout();
        test_reset_mid_burst();
        test_spurious_ack();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/wb_burst_master.md
# wb_burst_master

Wishbone master that sits directly upstream of the on-chip RAM slave and converts a simple CPU-side request port into Wishbone cycles. Single requests become classic cycles (cti 000) with byte selects; line-fill requests become incrementing read bursts (cti 010, final beat 111) of BURST_LEN words. Each returned word is forwarded to the requester as a registered response. A watchdog ends any cycle whose slave never acknowledges.

## Interface
- dat_width, 32, data bus width; fixed at 32.
- adr_width, 10, word-address width; matches the RAM slave.
- BURST_LEN, 4, words per line-fill burst; power of two, 2..16.
- TIMEOUT, 255, maximum cycles waited for an ack before abort; 1..255.

- clk_i, in, 1, single clock; all logic on posedge.
- rst_i, in, 1, reset; synchronous, active-high.
- req_i, in, 1, request valid.
- req_we_i, in, 1, 1 = write, 0 = read.
- req_burst_i, in, 1, 1 = line-fill read burst; ignored when req_we_i = 1.
- req_adr_i, in, adr_width, word address.
- req_dat_i, in, 32, write data.
- req_sel_i, in, 4, byte enables for single accesses.
- req_rdy_o, out, 1, request accepted when req_i & req_rdy_o.
- rsp_valid_o, out, 1, one-cycle pulse per completed beat.
- rsp_dat_o, out, 32, read data for the beat; holds its last value otherwise.
- rsp_last_o, out, 1, qualifies rsp_valid_o on the final beat; always 1 for singles.
- rsp_err_o, out, 1, qualifies rsp_valid_o on a timeout abort.
- wb_adr_o, out, adr_width, Wishbone address.
- wb_dat_o, out, 32, Wishbone write data.
- wb_dat_i, in, 32, Wishbone read data.
- wb_we_o, out, 1, Wishbone write enable.
- wb_sel_o, out, 4, Wishbone byte selects.
- wb_cyc_o, out, 1, Wishbone cycle.
- wb_stb_o, out, 1, Wishbone strobe.
- wb_cti_o, out, 3, Wishbone cycle-type identifier.
- wb_ack_i, in, 1, Wishbone acknowledge.

## Operation
- States: IDLE, SINGLE, BURST.
- **IDLE**
  - req_rdy_o = 1 only in IDLE.
  - On acceptance, register adr, dat, we and sel.
  - Go to BURST if req_burst_i & !req_we_i; otherwise go to SINGLE.
- **SINGLE**
  - Drive cyc = stb = 1, cti = 000, with the captured fields.
  - On wb_ack_i, at the same edge: drop cyc/stb, go to IDLE, and register the response.
  - Response is rsp_valid = 1, rsp_last = 1, rsp_dat = wb_dat_i. For writes, rsp_dat holds its previous value.
- **BURST**
  - Drive we = 0, sel = 1111, with beat counter k = 0.
  - cti = 010 while k < BURST_LEN-1; cti = 111 when k = BURST_LEN-1.
  - Each ack edge:
    - wb_adr_o increments by 1, wrapping modulo 2^adr_width (3FF -> 000).
    - k increments.
    - A response is registered with rsp_last = (k == BURST_LEN-1).
  - On the ack with k = BURST_LEN-1: drop cyc/stb and go to IDLE.
- **Watchdog**
  - Counter is cleared on entry to SINGLE/BURST and on every ack; it increments while cyc = 1 & !ack.
  - When it reaches TIMEOUT: drop cyc/stb, go to IDLE, and pulse rsp_valid with rsp_err = 1 and rsp_last = 1.
  - Remaining burst beats are abandoned.
- wb_ack_i while cyc = 0 is ignored.
- req_i outside IDLE is not accepted; the requester holds it.

## Timing
- **Reset values**: state IDLE; wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid_o, rsp_last_o and rsp_err_o = 0. wb_cti_o = 000; wb_sel_o = 0000; wb_adr_o, wb_dat_o and rsp_dat_o = 0.
- Reset asserted mid-cycle: cyc/stb drop at that edge, and no response is emitted for the aborted access.
- **Single against the RAM slave** (request accepted in cycle 0):
  - cyc/stb high in cycles 1-2; ack in cycle 2; rsp_valid in cycle 3.
  - Next request can be accepted in cycle 3, so there are 3 cycles per access.
- **Burst against the RAM slave**:
  - Ack is continuous in cycles 2..BURST_LEN+1.
  - rsp_valid is high in cycles 3..BURST_LEN+2, back-to-back.
  - cyc drops after the final ack.
- Response latency is always 1 cycle after the corresponding ack. All outputs are registered.

## Test plan
- **Single write then read**: write adr 005, dat 11223344, sel 1111, then read adr 005.
  - Write: wb_we_o = 1 and cti 000 for 2 cycles; rsp_valid = 1 with rsp_last = 1.
  - Read: rsp_dat_o = 11223344.
- **Byte write**: write adr 005, sel 0100, dat AABBCCDD over the previous word, then read -> rsp_dat_o = 11BB3344.
- **Line fill**: preload 010..013 with 0..3, then issue a burst read at 010 with BURST_LEN = 4.
  - Bus: cti sequence 010, 010, 010, 111; addresses 010..013.
  - Responses: four back-to-back rsp_valid with data 0..3; rsp_last only on the 4th.
- **Wrap-around**: burst at 3FE -> addresses 3FE, 3FF, 000, 001, no X on wb_adr_o.
- **Timeout**: hold wb_ack_i = 0 with TIMEOUT = 8.
  - cyc drops after 8 cycles; single rsp_valid with rsp_err = 1.
  - req_rdy_o returns to 1 the next cycle.
- **Reset and spurious ack**:
  - Assert rst_i during the 2nd burst beat: cyc/stb/rsp_valid are 0 the next cycle and no further responses appear.
  - Pulse wb_ack_i while idle: no rsp_valid.
